// File: rtl/mpu707_arb.sv
// Two-requester arbiter sharing one MPU707 (x0.7071) multiplier, with tag tracking
// through its pipeline. Define MPU707_ARB_RR_EN for round-robin contention, else fixed priority.
module mpu707_arb #(
    parameter int unsigned nb  = 16,
    parameter int unsigned LAT = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic [nb+1:0] DI0,
    output logic          ACK0,
    input  logic          REQ1,
    input  logic [nb+1:0] DI1,
    output logic          ACK1,
    output logic [nb+1:0] MDI,
    output logic          MEI,
    input  logic [nb+1:0] MDO,
    output logic [nb+1:0] DO,
    output logic          RDY0,
    output logic          RDY1,
    output logic          IDLE
);

    localparam int unsigned W = nb + 2;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    tag_t tag_q [LAT];
    logic mei_q;
    logic gnt0_c;
    logic gnt1_c;
    logic in_flight_c;

`ifdef MPU707_ARB_RR_EN
    logic rr_q;
`endif

    // Grant selection; reset suppresses any acknowledge
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!RST) begin
            if (REQ0 && REQ1) begin
`ifdef MPU707_ARB_RR_EN
                gnt0_c = !rr_q;
                gnt1_c = rr_q;
`else
                gnt0_c = 1'b1;
`endif
            end else begin
                gnt0_c = REQ0;
                gnt1_c = REQ1;
            end
        end
    end

    // Multiplier operand mux, zero when nothing is granted
    always_comb begin
        MDI = W'(0);
        if (gnt0_c) begin
            MDI = DI0;
        end else if (gnt1_c) begin
            MDI = DI1;
        end
    end

    // Tag pipe mirrors the multiplier's register stages
    always_ff @(posedge CLK) begin
        if (RST) begin
            mei_q <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
`ifdef MPU707_ARB_RR_EN
            rr_q <= 1'b0;
`endif
        end else begin
            mei_q       <= 1'b1;
            tag_q[0]    <= '{valid: gnt0_c | gnt1_c, id: gnt1_c};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
`ifdef MPU707_ARB_RR_EN
            if (REQ0 && REQ1) begin
                rr_q <= !rr_q;
            end
`endif
        end
    end

    always_comb begin
        in_flight_c = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            in_flight_c = in_flight_c | tag_q[i].valid;
        end
    end

    assign ACK0 = gnt0_c;
    assign ACK1 = gnt1_c;
    assign MEI  = mei_q;
    assign DO   = MDO;
    // Tags still in the pipe while reset is asserted belong to flushed operands
    assign RDY0 = !RST && tag_q[LAT-1].valid && !tag_q[LAT-1].id;
    assign RDY1 = !RST && tag_q[LAT-1].valid &&  tag_q[LAT-1].id;
    assign IDLE = RST || (!(gnt0_c || gnt1_c) && !in_flight_c);

endmodule
